// File: rtl/instruction_loader.sv
// Instruction-memory load master: assembles MSB-first words from a UART byte
// stream and issues one single-cycle write per word into the fetch stage.
module instruction_loader #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter int TO_WIDTH        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [7:0]            o_word_count
);

  localparam int                  BYTES     = SIZE / 8;
  localparam logic [7:0]          LAST_BYTE = 8'(BYTES - 1);
  localparam logic [8:0]          MAX_N     = 9'(MAX_INSTRUCTION);
  localparam logic [TO_WIDTH-1:0] TO_LAST   = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_COUNT,
    S_GET_BYTES,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [7:0]            r_count;
  logic [7:0]            r_word_idx;
  logic [7:0]            r_byte_idx;
  logic [SIZE-9:0]       r_shift;
  logic [TO_WIDTH-1:0]   r_timeout;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [SIZE-1:0]       r_write_data;
  logic [7:0]            r_word_count;

  logic                  w_rx_ready;
  logic                  w_accept;
  logic                  w_timeout_hit;
  logic [7:0]            w_next_word_idx;
  logic [SIZE-1:0]       w_next_shift;

  assign w_rx_ready      = (r_state == S_GET_COUNT) || (r_state == S_GET_BYTES);
  assign w_accept        = i_rx_valid && w_rx_ready;
  assign w_timeout_hit   = (r_timeout == TO_LAST);
  assign w_next_word_idx = r_word_idx + 8'd1;
  assign w_next_shift    = {r_shift, i_rx_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:      if (i_start) w_next_state = S_GET_COUNT;
      S_GET_COUNT: begin
        if (w_accept) begin
          if (i_rx_data == 8'd0)               w_next_state = S_DONE;
          else if ({1'b0, i_rx_data} > MAX_N) w_next_state = S_ERROR;
          else                                w_next_state = S_GET_BYTES;
        end else if (w_timeout_hit) begin
          w_next_state = S_ERROR;
        end
      end
      S_GET_BYTES: begin
        if (w_accept) begin
          if (r_byte_idx == LAST_BYTE) w_next_state = S_WRITE;
        end else if (w_timeout_hit) begin
          w_next_state = S_ERROR;
        end
      end
      S_WRITE:     w_next_state = (w_next_word_idx == r_count) ? S_DONE : S_GET_BYTES;
      S_DONE:      w_next_state = S_IDLE;
      S_ERROR:     if (i_start) w_next_state = S_GET_COUNT;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Idle counter only runs while waiting for bytes and restarts on every state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_shift      <= '0;
      r_timeout    <= '0;
      r_we         <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_word_count <= '0;
    end else begin
      r_we      <= (w_next_state == S_WRITE);
      r_timeout <= (w_rx_ready && !w_accept && (w_next_state == r_state)) ?
                   r_timeout + 1'b1 : '0;
      case (r_state)
        S_IDLE, S_ERROR: if (i_start) r_word_count <= '0;
        S_GET_COUNT: begin
          if (w_accept) begin
            r_count    <= i_rx_data;
            r_word_idx <= '0;
            r_byte_idx <= '0;
          end
        end
        S_GET_BYTES: begin
          if (w_accept) begin
            r_shift    <= w_next_shift[SIZE-9:0];
            r_byte_idx <= r_byte_idx + 8'd1;
            if (r_byte_idx == LAST_BYTE) begin
              r_write_data <= w_next_shift;
              r_write_addr <= r_word_idx[ADDR_WIDTH-1:0];
            end
          end
        end
        S_WRITE: begin
          r_word_idx   <= w_next_word_idx;
          r_word_count <= r_word_count + 8'd1;
          r_byte_idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rx_ready          = w_rx_ready;
  assign o_inst_write_enable = r_we;
  assign o_write_addr        = r_write_addr;
  assign o_write_data        = r_write_data;
  assign o_busy              = (r_state == S_GET_COUNT) || (r_state == S_GET_BYTES) ||
                               (r_state == S_WRITE)     || (r_state == S_DONE);
  assign o_done              = (r_state == S_DONE);
  assign o_error             = (r_state == S_ERROR);
  assign o_word_count        = r_word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: drives load sessions byte by byte and compares
// observed writes against words computed directly from the byte stream.
module tb_instruction_loader;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, we, busy, done, error;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [7:0]  word_count;

  instruction_loader #(
    .SIZE(32), .MAX_INSTRUCTION(64), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data),
    .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .o_inst_write_enable(we),
    .o_write_addr(addr), .o_write_data(wdata), .o_busy(busy), .o_done(done),
    .o_error(error), .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t        wq[$];
  int         doneq[$];
  logic [7:0] dq[$];
  int         lastq[$];
  int         last_cyc;
  int         errors = 0;
  int         checks = 0;

  // Every observed write strobe and done pulse is logged with its cycle number.
  always @(negedge clk) begin
    if (we)   wq.push_back('{cyc, addr, wdata});
    if (done) doneq.push_back(cyc);
  end

  function automatic logic [31:0] exp_word(input int w);
    logic [31:0] e = 32'h0;
    for (int k = 0; k < 4; k++) e = e | (32'(dq[4*w+k]) << (8*(3-k)));
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0; last_cyc = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic fill_random(input int n);
    dq.delete();
    for (int i = 0; i < 4*n; i++) dq.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic load_words(input int n, input bit do_start, input bit poke_start, output bit ok);
    wq.delete(); doneq.delete(); lastq.delete();
    if (do_start) pulse_start();
    send_byte(8'(n), 0);
    for (int i = 0; i < 4*n; i++) begin
      send_byte(dq[i], $urandom_range(0, 2));
      if (i % 4 == 3) lastq.push_back(last_cyc);
      if (poke_start && i == 1) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_reset();
    checks++; if ({we, addr, wdata, busy, done, error, word_count, rx_ready} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got we=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%0d rdy=%b want all 0",
                         we, addr, wdata, busy, done, error, word_count, rx_ready);
    end
  endtask

  task automatic test_two_words();
    bit ok;
    dq = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
    load_words(2, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL two_words_timeout got busy=%b want 0", busy); end
    checks++; if (wq.size() != 2) begin errors++; $display("[TB] FAIL two_words_count got %0d want 2", wq.size()); end
    for (int w = 0; w < wq.size() && w < 2; w++) begin
      checks++; if (wq[w].a !== 6'(w) || wq[w].d !== exp_word(w) || wq[w].c != lastq[w]) begin
        errors++; $display("[TB] FAIL two_words_write%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                           w, wq[w].a, wq[w].d, wq[w].c, w, exp_word(w), lastq[w]);
      end
    end
    checks++; if (doneq.size() != 1 || (wq.size() == 2 && doneq[0] != wq[1].c + 1)) begin
      errors++; $display("[TB] FAIL two_words_done got pulses=%0d want 1 right after last write", doneq.size());
    end
    checks++; if (word_count !== 8'd2 || error !== 1'b0) begin
      errors++; $display("[TB] FAIL two_words_status got cnt=%0d err=%b want cnt=2 err=0", word_count, error);
    end
  endtask

  task automatic test_count_zero();
    wq.delete(); doneq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    repeat (4) @(negedge clk);
    checks++; if (wq.size() != 0) begin errors++; $display("[TB] FAIL zero_writes got %0d want 0", wq.size()); end
    checks++; if (doneq.size() != 1 || doneq[0] < last_cyc || doneq[0] > last_cyc + 1) begin
      errors++; $display("[TB] FAIL zero_done got pulses=%0d want 1 within 2 cycles of byte", doneq.size());
    end
    checks++; if (busy !== 1'b0 || word_count !== 8'd0) begin
      errors++; $display("[TB] FAIL zero_status got busy=%b cnt=%0d want busy=0 cnt=0", busy, word_count);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    wq.delete();
    pulse_start();
    send_byte(8'h41, 0);
    checks++; if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL overflow_error got err=%b busy=%b rdy=%b want err=1 busy=0 rdy=0", error, busy, rx_ready);
    end
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1 || wq.size() != 0) begin
      errors++; $display("[TB] FAIL overflow_sticky got err=%b writes=%0d want err=1 writes=0", error, wq.size());
    end
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow_restart got err=%b busy=%b want err=0 busy=1", error, busy);
    end
    fill_random(1);
    load_words(1, 1'b0, 1'b0, ok);
    checks++; if (!ok || wq.size() != 1 || (wq.size() == 1 && (wq[0].d !== exp_word(0) || wq[0].a !== 6'd0))) begin
      errors++; $display("[TB] FAIL overflow_recover got ok=%b writes=%0d data=%h want 1 write of %h",
                         ok, wq.size(), (wq.size() > 0) ? wq[0].d : 32'h0, exp_word(0));
    end
  endtask

  task automatic test_timeout();
    int err_cyc;
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    err_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (error) begin err_cyc = cyc; break; end
      @(negedge clk);
    end
    checks++; if (err_cyc != last_cyc + TO) begin
      errors++; $display("[TB] FAIL timeout_cycle got %0d want %0d", err_cyc - last_cyc, TO);
    end
    checks++; if (wq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_nowrite got writes=%0d busy=%b want 0 0", wq.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    fill_random(1);
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(dq[0], 0);
    send_byte(dq[1], 0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({we, addr, wdata, busy, done, error, word_count, rx_ready} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_outputs got busy=%b data=%h addr=%0d cnt=%0d rdy=%b want all 0",
                         busy, wdata, addr, word_count, rx_ready);
    end
    rst = 1'b0;
    send_byte(dq[2], 0);
    send_byte(dq[3], 0);
    repeat (3) @(negedge clk);
    checks++; if (wq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_ignored got writes=%0d busy=%b want 0 0", wq.size(), busy);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    fill_random(2);
    load_words(2, 1'b1, 1'b1, ok);
    checks++; if (!ok || wq.size() != 2 || word_count !== 8'd2) begin
      errors++; $display("[TB] FAIL busy_start_count got ok=%b writes=%0d cnt=%0d want 2 2", ok, wq.size(), word_count);
    end
    checks++; if (wq.size() == 2 && (wq[0].d !== exp_word(0) || wq[1].d !== exp_word(1) || wq[1].a !== 6'd1)) begin
      errors++; $display("[TB] FAIL busy_start_data got %h %h want %h %h", wq[0].d, wq[1].d, exp_word(0), exp_word(1));
    end
  endtask

  task automatic test_start_with_byte();
    wq.delete(); doneq.delete();
    @(negedge clk); start = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    @(negedge clk); start = 1'b0; rx_valid = 1'b0;
    send_byte(8'h00, 0);
    repeat (4) @(negedge clk);
    checks++; if (doneq.size() != 1 || wq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL start_byte_dropped got done=%0d writes=%0d busy=%b want 1 0 0", doneq.size(), wq.size(), busy);
    end
  endtask

  task automatic test_random_loads();
    bit ok;
    int n;
    for (int s = 0; s < 4; s++) begin
      n = (s == 0) ? 64 : $urandom_range(1, 6);
      fill_random(n);
      load_words(n, 1'b1, 1'b0, ok);
      checks++; if (!ok || wq.size() != n || word_count !== 8'(n) || doneq.size() != 1) begin
        errors++; $display("[TB] FAIL random_session%0d got ok=%b writes=%0d cnt=%0d done=%0d want n=%0d",
                           s, ok, wq.size(), word_count, doneq.size(), n);
      end
      for (int w = 0; w < wq.size() && w < n; w++) begin
        checks++; if (wq[w].a !== 6'(w) || wq[w].d !== exp_word(w) || wq[w].c != lastq[w]) begin
          errors++; $display("[TB] FAIL random_write%0d_%0d got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             s, w, wq[w].a, wq[w].d, wq[w].c, w, exp_word(w), lastq[w]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_two_words();
    test_count_zero();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_busy_start();
    test_start_with_byte();
    test_random_loads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
